// File: rtl/sme_pkg.sv
// Shared types and default sizing for the strided memory engine.
package sme_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_LANES  = 8;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } smeState_e;

    function automatic int rowWidth(input int dataW, input int lanes);
        return dataW * lanes;
    endfunction

endpackage

// File: rtl/sme_if.sv
// One access port of the strided memory engine: burst request, write data and status.
interface sme_if #(
    parameter int AW    = 5,
    parameter int CNT_W = 8,
    parameter int ROW_W = 128
);
    logic [AW-1:0]    addrIn;
    logic [CNT_W-1:0] count;
    logic [AW-1:0]    strideIn;
    logic             writeEnIn;
    logic             validIn;
    logic [ROW_W-1:0] dataIn;
    logic [ROW_W-1:0] dataOut;
    logic             rdValid;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output addrIn, count, strideIn, writeEnIn, validIn, dataIn,
        input  dataOut, rdValid, busy, done, err
    );

    modport slave (
        input  addrIn, count, strideIn, writeEnIn, validIn, dataIn,
        output dataOut, rdValid, busy, done, err
    );
endinterface

// File: rtl/sme_agu.sv
// Per-port burst sequencer: latches a request and walks start + k*stride, one row per cycle.
//   state | meaning
//   IDLE  | waiting for a validIn strobe
//   RUN   | issuing one access per cycle, remain accesses left
//   FIN   | burst complete, done asserted for this cycle
module sme_agu
    import sme_pkg::*;
#(
    parameter int AW    = 5,
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    sme_if.slave          req,
    output logic          acc,
    output logic [AW-1:0] accAddr,
    output logic          accWe
);

    smeState_e        state;
    logic [AW-1:0]    addr;
    logic [AW-1:0]    stride;
    logic [CNT_W-1:0] remain;
    logic             we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr     <= '0;
            stride   <= '0;
            remain   <= '0;
            we       <= 1'b0;
            req.busy <= 1'b0;
            req.done <= 1'b0;
            req.err  <= 1'b0;
        end else begin
            req.done <= 1'b0;
            // A strobe while a burst is active is dropped and flagged.
            req.err  <= req.validIn && (state != IDLE);
            case (state)
                IDLE: begin
                    if (req.validIn) begin
                        addr     <= req.addrIn;
                        stride   <= req.strideIn;
                        remain   <= req.count;
                        we       <= req.writeEnIn;
                        req.busy <= 1'b1;
                        if (req.count == '0) begin
                            state    <= FIN;
                            req.done <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    // AW-bit add wraps the row address modulo DEPTH.
                    addr   <= addr + stride;
                    remain <= remain - CNT_W'(1);
                    if (remain == CNT_W'(1)) begin
                        state    <= FIN;
                        req.done <= 1'b1;
                    end
                end
                FIN: begin
                    state    <= IDLE;
                    req.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    req.busy <= 1'b0;
                end
            endcase
        end
    end

    assign acc     = (state == RUN);
    assign accAddr = addr;
    assign accWe   = we;

endmodule

// File: rtl/strided_mem_engine.sv
// Two independent strided burst ports sharing a read-first dual-port row memory.
module strided_mem_engine
    import sme_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int LANES  = DEF_LANES,
    parameter  int DEPTH  = DEF_DEPTH,
    parameter  int CNT_W  = DEF_CNT_W,
    localparam int ROW_W  = LANES * DATA_W,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,

    input  logic [AW-1:0]    addrIn1,
    input  logic [CNT_W-1:0] count1,
    input  logic [AW-1:0]    strideIn1,
    input  logic             writeEnIn1,
    input  logic             validIn1,
    input  logic [ROW_W-1:0] dataIn1,
    output logic [ROW_W-1:0] dataOut1,
    output logic             rdValid1,
    output logic             busy1,
    output logic             done1,
    output logic             err1,

    input  logic [AW-1:0]    addrIn2,
    input  logic [CNT_W-1:0] count2,
    input  logic [AW-1:0]    strideIn2,
    input  logic             writeEnIn2,
    input  logic             validIn2,
    input  logic [ROW_W-1:0] dataIn2,
    output logic [ROW_W-1:0] dataOut2,
    output logic             rdValid2,
    output logic             busy2,
    output logic             done2,
    output logic             err2
);

    sme_if #(.AW(AW), .CNT_W(CNT_W), .ROW_W(ROW_W)) p1 ();
    sme_if #(.AW(AW), .CNT_W(CNT_W), .ROW_W(ROW_W)) p2 ();

    assign p1.addrIn    = addrIn1;
    assign p1.count     = count1;
    assign p1.strideIn  = strideIn1;
    assign p1.writeEnIn = writeEnIn1;
    assign p1.validIn   = validIn1;
    assign p1.dataIn    = dataIn1;
    assign dataOut1     = p1.dataOut;
    assign rdValid1     = p1.rdValid;
    assign busy1        = p1.busy;
    assign done1        = p1.done;
    assign err1         = p1.err;

    assign p2.addrIn    = addrIn2;
    assign p2.count     = count2;
    assign p2.strideIn  = strideIn2;
    assign p2.writeEnIn = writeEnIn2;
    assign p2.validIn   = validIn2;
    assign p2.dataIn    = dataIn2;
    assign dataOut2     = p2.dataOut;
    assign rdValid2     = p2.rdValid;
    assign busy2        = p2.busy;
    assign done2        = p2.done;
    assign err2         = p2.err;

    logic          acc1, acc2;
    logic [AW-1:0] accAddr1, accAddr2;
    logic          accWe1, accWe2;

    sme_agu #(.AW(AW), .CNT_W(CNT_W)) uAgu1 (
        .clk     (clk),
        .rst     (rst),
        .req     (p1),
        .acc     (acc1),
        .accAddr (accAddr1),
        .accWe   (accWe1)
    );

    sme_agu #(.AW(AW), .CNT_W(CNT_W)) uAgu2 (
        .clk     (clk),
        .rst     (rst),
        .req     (p2),
        .acc     (acc2),
        .accAddr (accAddr2),
        .accWe   (accWe2)
    );

    logic [ROW_W-1:0] mem [DEPTH];

    logic wr1, wr2, rd1, rd2;
    assign wr1 = !rst && acc1 &&  accWe1;
    assign wr2 = !rst && acc2 &&  accWe2;
    assign rd1 = !rst && acc1 && !accWe1;
    assign rd2 = !rst && acc2 && !accWe2;

    // No reset on the array; port 1 is written last so it wins a same-row collision.
    always_ff @(posedge clk) begin
        if (wr2) mem[accAddr2] <= p2.dataIn;
        if (wr1) mem[accAddr1] <= p1.dataIn;
    end

    // Reads sample the array before this edge's writes land, giving read-first behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            p1.rdValid <= 1'b0;
            p1.dataOut <= '0;
            p2.rdValid <= 1'b0;
            p2.dataOut <= '0;
        end else begin
            p1.rdValid <= rd1;
            p2.rdValid <= rd2;
            if (rd1) p1.dataOut <= mem[accAddr1];
            if (rd2) p2.dataOut <= mem[accAddr2];
        end
    end

endmodule

// File: tb/tb_strided_mem_engine.sv
// Directed and randomized bursts on both ports, checked against a row-array reference model.
module tb_strided_mem_engine;

    localparam int DATA_W = 16;
    localparam int LANES  = 8;
    localparam int DEPTH  = 32;
    localparam int CNT_W  = 8;
    localparam int ROW_W  = LANES * DATA_W;
    localparam int AW     = $clog2(DEPTH);

    logic clk;
    logic rst;
    int   nCmp;
    int   nErr;

    logic [ROW_W-1:0] model [DEPTH];

    sme_if #(.AW(AW), .CNT_W(CNT_W), .ROW_W(ROW_W)) p1if ();
    sme_if #(.AW(AW), .CNT_W(CNT_W), .ROW_W(ROW_W)) p2if ();

    strided_mem_engine #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .addrIn1    (p1if.addrIn),
        .count1     (p1if.count),
        .strideIn1  (p1if.strideIn),
        .writeEnIn1 (p1if.writeEnIn),
        .validIn1   (p1if.validIn),
        .dataIn1    (p1if.dataIn),
        .dataOut1   (p1if.dataOut),
        .rdValid1   (p1if.rdValid),
        .busy1      (p1if.busy),
        .done1      (p1if.done),
        .err1       (p1if.err),
        .addrIn2    (p2if.addrIn),
        .count2     (p2if.count),
        .strideIn2  (p2if.strideIn),
        .writeEnIn2 (p2if.writeEnIn),
        .validIn2   (p2if.validIn),
        .dataIn2    (p2if.dataIn),
        .dataOut2   (p2if.dataOut),
        .rdValid2   (p2if.rdValid),
        .busy2      (p2if.busy),
        .done2      (p2if.done),
        .err2       (p2if.err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chkBit(input string tag, input logic obs, input logic exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkRow(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [ROW_W-1:0] rndRow();
        logic [ROW_W-1:0] r;
        r = '0;
        for (int i = 0; i < ROW_W / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic setReq(input int p, input int a, input int n, input int s, input bit we, input bit v);
        if (p == 1) begin
            p1if.addrIn = AW'(a); p1if.count = CNT_W'(n); p1if.strideIn = AW'(s);
            p1if.writeEnIn = we;  p1if.validIn = v;
        end else begin
            p2if.addrIn = AW'(a); p2if.count = CNT_W'(n); p2if.strideIn = AW'(s);
            p2if.writeEnIn = we;  p2if.validIn = v;
        end
    endtask

    task automatic setData(input int p, input logic [ROW_W-1:0] d);
        if (p == 1) p1if.dataIn = d;
        else        p2if.dataIn = d;
    endtask

    function automatic logic busyOf(input int p);    return (p == 1) ? p1if.busy    : p2if.busy;    endfunction
    function automatic logic doneOf(input int p);    return (p == 1) ? p1if.done    : p2if.done;    endfunction
    function automatic logic errOf(input int p);     return (p == 1) ? p1if.err     : p2if.err;     endfunction
    function automatic logic rdvOf(input int p);     return (p == 1) ? p1if.rdValid : p2if.rdValid; endfunction
    function automatic logic [ROW_W-1:0] doutOf(input int p);
        return (p == 1) ? p1if.dataOut : p2if.dataOut;
    endfunction

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    // Drives one burst from the idle state and checks every cycle until the port is idle again.
    // pat=1 writes rows of k+1 in every lane; errCycle>0 injects a stray strobe in that cycle.
    task automatic burst(input int p, input int a, input int n, input int s, input bit we,
                         input int pat, input int errCycle, input string tag);
        int               rows[$];
        logic [ROW_W-1:0] wd[$];
        for (int k = 0; k < n; k++) begin
            rows.push_back((a + k * s) % DEPTH);
            wd.push_back((pat == 1) ? {LANES{DATA_W'(k + 1)}} : rndRow());
        end
        setReq(p, a, n, s, we, 1'b1);
        for (int c = 1; c <= n + 1; c++) begin
            cycle();
            if (c == errCycle) setReq(p, $urandom_range(0, DEPTH - 1), 2, 1, ~we, 1'b1);
            else               setReq(p, 0, 0, 0, 1'b0, 1'b0);
            setData(p, (c <= n) ? wd[c-1] : rndRow());
            @(negedge clk);
            chkBit({tag, " busy"}, busyOf(p), 1'b1);
            chkBit({tag, " done"}, doneOf(p), c == n + 1);
            chkBit({tag, " err"}, errOf(p), (errCycle > 0) && (c == errCycle + 1));
            chkBit({tag, " rdValid"}, rdvOf(p), !we && (c >= 2));
            if (!we && c >= 2) chkRow({tag, " dataOut"}, doutOf(p), model[rows[c-2]]);
            if (we && c <= n) model[rows[c-1]] = wd[c-1];
        end
        cycle();
        setData(p, rndRow());
        @(negedge clk);
        chkBit({tag, " idle busy"}, busyOf(p), 1'b0);
        chkBit({tag, " idle done"}, doneOf(p), 1'b0);
        chkBit({tag, " idle rdValid"}, rdvOf(p), 1'b0);
        if (!we && n > 0) chkRow({tag, " dataOut hold"}, doutOf(p), model[rows[n-1]]);
    endtask

    initial begin
        logic [ROW_W-1:0] dA, dB, oldRow;
        logic [ROW_W-1:0] rw [6];
        nCmp = 0;
        nErr = 0;
        rst  = 1'b1;
        setReq(1, 0, 0, 0, 1'b0, 1'b0);
        setReq(2, 0, 0, 0, 1'b0, 1'b0);
        setData(1, '0);
        setData(2, '0);

        // Reset with a strobe held on port 1; it must be ignored.
        setReq(1, 3, 4, 1, 1'b1, 1'b1);
        cycle();
        @(negedge clk);
        for (int p = 1; p <= 2; p++) begin
            chkBit("reset busy", busyOf(p), 1'b0);
            chkBit("reset done", doneOf(p), 1'b0);
            chkBit("reset err", errOf(p), 1'b0);
            chkBit("reset rdValid", rdvOf(p), 1'b0);
            chkRow("reset dataOut", doutOf(p), '0);
        end
        cycle();
        rst = 1'b0;
        setReq(1, 0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        chkBit("strobe in reset ignored", busyOf(1), 1'b0);
        cycle();

        burst(1, 0, DEPTH, 1, 1'b1, 0, 0, "init fill");
        burst(1, 0, 3, 1, 1'b1, 1, 0, "wr 1/2/3");
        chkRow("row0 lanes=1", model[0], {LANES{16'd1}});
        burst(2, 0, 3, 1, 1'b0, 0, 0, "rd 1/2/3");
        burst(1, 30, 4, 1, 1'b1, 0, 0, "wrap wr");
        burst(2, 30, 4, 1, 1'b0, 0, 0, "wrap rd");
        burst(1, 7, 0, 1, 1'b1, 0, 0, "count0 wr");
        burst(1, 7, 1, 1, 1'b0, 0, 0, "count0 check");
        burst(2, 9, 3, 0, 1'b1, 0, 0, "stride0 wr");
        burst(2, 9, 2, 0, 1'b0, 0, 0, "stride0 rd");
        burst(1, 12, 5, 3, 1'b1, 0, 2, "err wr");
        burst(2, 12, 5, 3, 1'b0, 0, 0, "err check");
        burst(2, 4, 5, 29, 1'b0, 0, 2, "err rd");

        for (int i = 0; i < 14; i++) begin
            burst($urandom_range(1, 2), $urandom_range(0, DEPTH - 1), $urandom_range(0, 6),
                  $urandom_range(0, DEPTH - 1), 1'($urandom_range(0, 1)), 0, 0, "random");
        end

        // Both ports write row 5 in the same cycle: port 1 must win.
        setReq(1, 5, 1, 0, 1'b1, 1'b1);
        setReq(2, 5, 1, 0, 1'b1, 1'b1);
        cycle();
        setReq(1, 0, 0, 0, 1'b0, 1'b0);
        setReq(2, 0, 0, 0, 1'b0, 1'b0);
        dA = rndRow();
        dB = rndRow();
        setData(1, dA);
        setData(2, dB);
        @(negedge clk);
        chkBit("collide busy1", busyOf(1), 1'b1);
        chkBit("collide busy2", busyOf(2), 1'b1);
        cycle();
        @(negedge clk);
        chkBit("collide done1", doneOf(1), 1'b1);
        chkBit("collide done2", doneOf(2), 1'b1);
        model[5] = dA;
        cycle();
        burst(2, 5, 1, 0, 1'b0, 0, 0, "collide rd");

        // Port 2 reads row 6 while port 1 writes it: old contents come back.
        oldRow = model[6];
        setReq(1, 6, 1, 0, 1'b1, 1'b1);
        setReq(2, 6, 1, 0, 1'b0, 1'b1);
        cycle();
        setReq(1, 0, 0, 0, 1'b0, 1'b0);
        setReq(2, 0, 0, 0, 1'b0, 1'b0);
        dA = rndRow();
        setData(1, dA);
        cycle();
        @(negedge clk);
        chkBit("rdfirst rdValid", rdvOf(2), 1'b1);
        chkRow("rdfirst dataOut", doutOf(2), oldRow);
        model[6] = dA;
        cycle();
        burst(2, 6, 1, 0, 1'b0, 0, 0, "rdfirst new");

        // Reset in the third issue cycle of a 6-row write: only rows 20 and 21 change.
        for (int k = 0; k < 6; k++) rw[k] = rndRow();
        setReq(1, 20, 6, 1, 1'b1, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            cycle();
            setReq(1, 0, 0, 0, 1'b0, 1'b0);
            setData(1, rw[c-1]);
            if (c == 3) rst = 1'b1;
            @(negedge clk);
            chkBit("pre-reset busy", busyOf(1), 1'b1);
            chkBit("pre-reset done", doneOf(1), 1'b0);
            if (c <= 2) model[20 + c - 1] = rw[c-1];
        end
        cycle();
        rst = 1'b0;
        @(negedge clk);
        chkBit("abort busy", busyOf(1), 1'b0);
        chkBit("abort done", doneOf(1), 1'b0);
        chkRow("abort dataOut1", doutOf(1), '0);
        chkRow("abort dataOut2", doutOf(2), '0);
        for (int c = 0; c < 4; c++) begin
            cycle();
            @(negedge clk);
            chkBit("post-abort done", doneOf(1), 1'b0);
            chkBit("post-abort busy", busyOf(1), 1'b0);
        end
        burst(2, 20, 6, 1, 1'b0, 0, 0, "abort rows");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule

// File: doc/strided_mem_engine.md
STRIDED_MEM_ENGINE -- requirements
Module: strided_mem_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning bits per lane word.
REQ-002 SHALL have parameter LANES, default 8, meaning words per memory row; ROW_W = LANES*DATA_W.
REQ-003 SHALL have parameter DEPTH, default 32, meaning rows, power of two; AW = log2(DEPTH).
REQ-004 SHALL have parameter CNT_W, default 8, meaning access-count width.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-007 SHALL have, for p in {1,2}, port addrIn{p}, input, AW, meaning start row.
REQ-008 SHALL have, for each p, port count{p}, input, CNT_W, meaning number of accesses.
REQ-009 SHALL have, for each p, port strideIn{p}, input, AW, meaning row increment.
REQ-010 SHALL have, for each p, port writeEnIn{p}, input, 1, meaning 1 = write burst, 0 = read burst.
REQ-011 SHALL have, for each p, port validIn{p}, input, 1, meaning one-cycle start strobe.
REQ-012 SHALL have, for each p, port dataIn{p}, input, ROW_W, meaning write data.
REQ-013 SHALL have, for each p, port dataOut{p}, output, ROW_W, meaning read data.
REQ-014 SHALL have, for each p, port rdValid{p}, output, 1, meaning dataOut{p} is valid.
REQ-015 SHALL have, for each p, port busy{p}, output, 1, meaning a burst is in progress.
REQ-016 SHALL have, for each p, port done{p}, output, 1, meaning one-cycle burst-complete pulse.
REQ-017 SHALL have, for each p, port err{p}, output, 1, meaning one-cycle pulse for a rejected start.

Function
REQ-018 SHALL give each port an independent FSM with states IDLE, RUN and FIN.
REQ-019 SHALL, when validIn{p} is 1 in IDLE, latch addr/count/stride/writeEn and go to RUN when count>0, or to FIN when count==0.
REQ-020 SHALL, in RUN, issue exactly one access per cycle, k = 0..count-1, to row (start + k*stride) mod DEPTH, with wrap-around by AW-bit truncation.
REQ-021 SHALL issue the first access in the cycle after the validIn strobe, with no bubbles between accesses.
REQ-022 SHALL, on a write access, store dataIn{p} as sampled in the issue cycle into the addressed row.
REQ-023 SHALL, on a read access, present dataOut{p} with rdValid{p}=1 one cycle after issue; dataOut{p} holds its value while rdValid{p}=0.
REQ-024 SHALL go from RUN to FIN after the last issue; FIN asserts done{p} for one cycle and returns to IDLE.
REQ-025 SHALL, for count==0, perform no memory access and pulse done{p} in the cycle after the strobe.
REQ-026 SHALL assert busy{p}=1 in RUN and FIN, and 0 in IDLE.
REQ-027 SHALL, when validIn{p} is 1 while busy{p}=1, ignore the strobe, leave the burst undisturbed and pulse err{p} the next cycle.
REQ-028 SHALL, when both ports write the same row in the same cycle, store the port-1 data.
REQ-029 SHALL, when one port reads a row that the other port writes in the same cycle, return the old contents (read-first).
REQ-030 SHALL, when stride==0, access the same row count times.

Reset
REQ-031 SHALL, while rst=1 at a clock edge, force every FSM to IDLE and drive all outputs (dataOut, rdValid, busy, done, err) to 0 on the next cycle.
REQ-032 SHALL, on reset mid-burst, abort the burst with no done pulse; writes already issued remain stored.
REQ-033 SHALL NOT reset memory contents.
REQ-034 SHALL ignore validIn during the reset cycle.

Structure
REQ-035 SHALL place the FSM state enum and the default parameter constants in a shared package sme_pkg.
REQ-036 SHALL implement the per-port FSM and address generator as sub-module sme_agu, instantiated twice.
REQ-037 SHALL implement the row memory inline as a DEPTH x ROW_W dual-port array.

Verification
REQ-038 SHALL cover: port-1 write, addr 0, count 3, stride 1, data rows all-1, all-2, all-3 -> rows 0/1/2 hold 1/2/3 in every lane and done1 pulses in cycle 4 after the strobe.
REQ-039 SHALL cover: port-2 read, addr 0, count 3, stride 1 after that write -> rdValid2 high for 3 consecutive cycles with dataOut2 = rows of 1, 2, 3.
REQ-040 SHALL cover: port-1 write, addr 30, count 4, stride 1, DEPTH 32 -> rows 30, 31, 0 and 1 written in that order.
REQ-041 SHALL cover: count 0 strobe -> no write, done pulses in the next cycle, busy high for 1 cycle.
REQ-042 SHALL cover: validIn1 in cycle 2 of a 5-access burst -> err1 pulses once and the original 5 accesses complete unchanged.
REQ-043 SHALL cover: both ports write row 5 in the same cycle with data A and B -> row 5 holds A; a separate case with rst mid-burst -> busy 0, no done pulse, and only the rows issued before reset are modified.
